// File: rtl/uart_pkg.sv
// Shared encodings and elaboration helpers for the UART receive monitor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMP_A     = 7;
  localparam int SAMP_B     = 8;
  localparam int SAMP_C     = 9;

  // Rounded clocks-per-tick for 16x oversampling.
  function automatic int calc_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + 8 * baud) / (16 * baud));
  endfunction

  function automatic int entry_w(input int data_bits, input bit parity_en);
    return data_bits + 1 + (parity_en ? 1 : 0);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; read data is forced to zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     gclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp];
  assign level   = cnt;

  always_ff @(posedge gclk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 16x-oversampled UART receiver with majority vote feeding an error-tagged FIFO.
// Optional parity checking is built when UART_RX_MONITOR_PARITY_EN is defined.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  input  logic                          enable_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          rd_ferr_o,
  output logic                          rd_perr_o,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  input  logic                          clear_i
);
`ifdef UART_RX_MONITOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int EW  = entry_w(DATA_BITS, PAR_EN);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_monitor: clock too slow for BAUD (DIV < 2)");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_par_chk
    $error("uart_rx_monitor: illegal parameter combination");
  end

  rx_state_e            state_q, state_d;
  logic                 rx_m, rx_s, armed_q;
  logic [PW-1:0]        pre_q;
  logic [TW-1:0]        tcnt_q;
  logic                 s7_q, s8_q;
  logic [2:0]           bcnt_q;
  logic                 scnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 ferr_q;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic                 perr_q;
`endif
  logic                 tick, decide, bit_v, ferr_now, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        wdata, rdata;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) {rx_m, rx_s} <= 2'b11;
    else          {rx_m, rx_s} <= {rx_i, rx_m};
  end

  assign tick     = (pre_q == PW'(DIV - 1));
  assign decide   = tick && (tcnt_q == TW'(SAMP_C));
  assign bit_v    = maj3(s7_q, s8_q, rx_s);
  assign ferr_now = ferr_q | ~bit_v;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (armed_q && !rx_s) state_d = ST_START;
        ST_START: if (decide) state_d = bit_v ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (decide && bcnt_q == 3'(DATA_BITS - 1))
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        ST_PARITY: if (decide) state_d = ST_STOP;
`endif
        ST_STOP: begin
          // Leave at mid-stop so the next start edge is caught despite rate error.
          if (decide && scnt_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            push    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      armed_q <= 1'b0;
      pre_q   <= '0;
      tcnt_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      if (state_q == ST_IDLE) begin
        pre_q  <= '0;
        tcnt_q <= '0;
      end else begin
        pre_q <= tick ? '0 : pre_q + PW'(1);
        if (tick) tcnt_q <= tcnt_q + TW'(1);
      end
      // Line must be seen high in IDLE before a low counts as a start edge.
      armed_q <= enable_i && (state_q == ST_IDLE) && (armed_q || rx_s);
      if (tick && tcnt_q == TW'(SAMP_A)) s7_q <= rx_s;
      if (tick && tcnt_q == TW'(SAMP_B)) s8_q <= rx_s;
      if (decide) begin
        case (state_q)
          ST_START: begin
            bcnt_q <= '0;
            scnt_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
            perr_q <= 1'b0;
`endif
          end
          ST_DATA: begin
            shreg_q <= {bit_v, shreg_q[DATA_BITS-1:1]};
            bcnt_q  <= bcnt_q + 3'd1;
          end
`ifdef UART_RX_MONITOR_PARITY_EN
          ST_PARITY: perr_q <= bit_v ^ (^shreg_q) ^ 1'(PARITY_ODD);
`endif
          ST_STOP: begin
            ferr_q <= ferr_now;
            scnt_q <= scnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_MONITOR_PARITY_EN
  assign wdata     = {perr_q, ferr_now, shreg_q};
  assign rd_perr_o = rdata[EW-1];
`else
  assign wdata     = {ferr_now, shreg_q};
  assign rd_perr_o = 1'b0;
`endif

  assign pop = rd_ready_i & ~fifo_empty;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk  (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign rd_valid_o = ~fifo_empty;
  assign rd_data_o  = rdata[DATA_BITS-1:0];
  assign rd_ferr_o  = rdata[DATA_BITS];

  // A fresh drop wins over a simultaneous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                           overflow_o <= 1'b0;
    else if (push && fifo_full && !pop)     overflow_o <= 1'b1;
    else if (clear_i)                       overflow_o <= 1'b0;
  end

endmodule
